apu_nn_responder: RTL
=====================

APU_NN_RESPONDER -- requirements
Module: apu_nn_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter MAX_LAT, default 4: depth of the in-flight result pipeline; must be ≥ the largest class latency.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port apu_req_i, input, 1: request from core.
REQ-006 SHALL have port apu_gnt_o, output, 1: grant; the request is accepted in a cycle where apu_req_i and apu_gnt_o are both 1.
REQ-007 SHALL have port apu_operands_i, input, 3xWIDTH: operands a, b, c.
REQ-008 SHALL have port apu_op_i, input, 6: operation code.
REQ-009 SHALL have port apu_flags_i, input, 15: request flags; sampled but unused.
REQ-010 SHALL have port apu_rvalid_o, output, 1: result valid, one-cycle pulse; no backpressure.
REQ-011 SHALL have port apu_result_o, output, WIDTH: result.
REQ-012 SHALL have port apu_flags_o, output, 5: status flags.

Function
REQ-013 Ops, latency L: 0 ADD a+b, L=PIPE_REG_ADDSUB(1); 1 SUB a-b, L=1; 2 MUL low WIDTH bits of a*b, L=PIPE_REG_MULT(1); 3 MAC a*b+c mod 2^WIDTH, L=PIPE_REG_MAC(2); 4 DIVU a/b unsigned, L=4; other codes illegal: L=1, result 0, flag bit2.
REQ-014 SHALL compute the result in the accept cycle and carry it through a MAX_LAT-entry slot pipeline: the op is written to slot L-1, and every slot shifts toward slot 0 each cycle.
REQ-015 An op accepted in cycle t SHALL assert apu_rvalid_o in exactly cycle t+L, with its result and flags, for one cycle.
REQ-016 Results SHALL return in acceptance order.
REQ-017 apu_gnt_o SHALL be combinational. It is 1 iff, after this cycle's shift, target slot L-1 is free and every slot with index > L-1 is free.
REQ-018 A request SHALL stall when an op with a longer remaining latency is in flight, e.g. ADD issued one cycle after DIVU waits until the DIVU result reaches slot 0.
REQ-019 Back-to-back ops of equal latency SHALL be granted every cycle. Full throughput is 1 op/cycle.
REQ-020 DIVU with b=0 SHALL return all-ones. It does not stall.
REQ-021 When no slot is retiring, apu_rvalid_o SHALL be 0 and apu_result_o/apu_flags_o SHALL be 0.
REQ-022 When slot 0 retires in the same cycle as a new L=1 accept, both SHALL be honoured: the retiring op drives rvalid, and the new op occupies slot 0 next cycle.
REQ-023 Operand changes without acceptance SHALL have no effect.

Reset
REQ-024 On rst_n=0, all slots SHALL be cleared immediately, asynchronously, and apu_rvalid_o, apu_result_o and apu_flags_o SHALL be 0.
REQ-025 Ops in flight at reset SHALL be dropped and never returned.
REQ-026 apu_gnt_o SHALL be 0 while rst_n=0. The first grant is possible in the first cycle after release.

Configuration
REQ-027 Macro APU_RESP_FLAGS_EN defined: apu_flags_o bit0 = DIVU by zero, bit1 = signed overflow on ADD/SUB, bit2 = illegal op, bits4:3 = 0.
REQ-028 Macro APU_RESP_FLAGS_EN undefined: apu_flags_o SHALL be constant 0, no flag storage SHALL exist in the slots, and illegal ops still return result 0.

Structure
REQ-029 Op codes, the op-to-latency table, the flag bit indices and the default MAX_LAT SHALL live in the shared APU core package, next to the existing PIPE_REG_* constants.
REQ-030 One sub-module, apu_nn_resp_slot_pipe, SHALL hold the slot shift register (valid, result, flags), the write port and the occupancy vector.
REQ-031 The arithmetic SHALL live in the top module.

Verification
REQ-032 Reset released; ADD a=3, b=4 accepted at cycle 10 -> rvalid at 11 only, result 7, flags 0.
REQ-033 MAC a=2, b=5, c=1 at t=0, then MUL a=6, b=7 requested at t=1 -> MUL gnt=0 at t=1, gnt=1 at t=2; rvalid at 2 (11), then at 3 (42).
REQ-034 DIVU a=100, b=0 -> result 0xFFFFFFFF after 4 cycles; flags 0x01 with APU_RESP_FLAGS_EN, 0x00 without.
REQ-035 Eight consecutive SUB requests, req held high -> gnt high all 8 cycles, rvalid high 8 consecutive cycles, results in order; SUB 0x80000000-1 gives flag bit1.
REQ-036 DIVU accepted, rst_n pulsed low 2 cycles later -> no rvalid ever for that DIVU, outputs 0 during reset, gnt=1 on the first cycle after release.
REQ-037 apu_op_i=6 accepted -> rvalid next cycle, result 0, flag bit2 set (when APU_RESP_FLAGS_EN is defined).

Source files
------------

// File: rtl/apu_nn_responder_pkg.sv
// Shared APU core constants: pipeline register depths, op codes, op-to-latency table
// and status flag bit positions used by the apu_nn_responder slice.
package apu_nn_responder_pkg;

    localparam int PIPE_REG_ADDSUB = 1;
    localparam int PIPE_REG_MULT   = 1;
    localparam int PIPE_REG_MAC    = 2;
    localparam int LAT_DIVU        = 4;
    localparam int LAT_ILLEGAL     = 1;

    localparam int APU_NN_MAX_LAT = 4;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_MUL  = 6'd2;
    localparam logic [5:0] OP_MAC  = 6'd3;
    localparam logic [5:0] OP_DIVU = 6'd4;

    localparam int FLAGS_W      = 5;
    localparam int FLAG_DIV0    = 0;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_ILLEGAL = 2;

    function automatic int unsigned op_latency(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB: return PIPE_REG_ADDSUB;
            OP_MUL:         return PIPE_REG_MULT;
            OP_MAC:         return PIPE_REG_MAC;
            OP_DIVU:        return LAT_DIVU;
            default:        return LAT_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/apu_nn_resp_slot_pipe.sv
// In-flight result slots: every slot shifts toward slot 0 each cycle, slot 0 retires.
// Flag storage exists only when APU_RESP_FLAGS_EN is defined.
module apu_nn_resp_slot_pipe
    import apu_nn_responder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_LAT = APU_NN_MAX_LAT,
    parameter int IDX_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_slot,
    input  logic [WIDTH-1:0]   wr_result,
`ifdef APU_RESP_FLAGS_EN
    input  logic [FLAGS_W-1:0] wr_flags,
    output logic [FLAGS_W-1:0] rd_flags,
`endif
    output logic [MAX_LAT-1:0] occupancy,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_result
);

    logic [MAX_LAT-1:0] valid;
    logic [WIDTH-1:0]   result [MAX_LAT];

    // The write lands after the shift, so a write into slot 0 coexists with a retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < MAX_LAT; i++) result[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_LAT - 1; i++) begin
                valid[i]  <= valid[i+1];
                result[i] <= result[i+1];
            end
            valid[MAX_LAT-1]  <= 1'b0;
            result[MAX_LAT-1] <= '0;
            if (wr_en) begin
                valid[wr_slot]  <= 1'b1;
                result[wr_slot] <= wr_result;
            end
        end
    end

`ifdef APU_RESP_FLAGS_EN
    logic [FLAGS_W-1:0] flags [MAX_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LAT; i++) flags[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_LAT - 1; i++) flags[i] <= flags[i+1];
            flags[MAX_LAT-1] <= '0;
            if (wr_en) flags[wr_slot] <= wr_flags;
        end
    end

    assign rd_flags = valid[0] ? flags[0] : '0;
`endif

    assign occupancy = valid;
    assign rd_valid  = valid[0];
    assign rd_result = valid[0] ? result[0] : '0;

endmodule

// File: rtl/apu_nn_responder.sv
// APU responder: computes the result at accept time and returns it after the op's latency.
// Optional status flags are enabled by defining APU_RESP_FLAGS_EN.
module apu_nn_responder
    import apu_nn_responder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_LAT = APU_NN_MAX_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  apu_req_i,
    output logic                  apu_gnt_o,
    input  logic [2:0][WIDTH-1:0] apu_operands_i,
    input  logic [5:0]            apu_op_i,
    input  logic [14:0]           apu_flags_i,
    output logic                  apu_rvalid_o,
    output logic [WIDTH-1:0]      apu_result_o,
    output logic [FLAGS_W-1:0]    apu_flags_o
);

    localparam int IDX_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    logic [WIDTH-1:0]   op_a, op_b, op_c, res;
    int unsigned        lat;
    logic [MAX_LAT-1:0] occupancy;
    logic [IDX_W-1:0]   wr_slot;
    logic               accept;
    logic               unused_req_flags;

    assign op_a = apu_operands_i[0];
    assign op_b = apu_operands_i[1];
    assign op_c = apu_operands_i[2];

    assign unused_req_flags = ^apu_flags_i;

    assign lat     = op_latency(apu_op_i);
    assign wr_slot = IDX_W'(lat - 1);

    // After the shift, slot k holds today's slot k+1: slots >= L-1 are free iff slots >= L are empty now.
    // Any in-flight op returning later than this one would break in-order return.
    assign apu_gnt_o = rst_n & ~|(occupancy >> lat);
    assign accept    = apu_req_i & apu_gnt_o;

    always_comb begin
        res = '0;
        case (apu_op_i)
            OP_ADD:  res = op_a + op_b;
            OP_SUB:  res = op_a - op_b;
            OP_MUL:  res = op_a * op_b;
            OP_MAC:  res = op_a * op_b + op_c;
            OP_DIVU: res = (op_b == '0) ? '1 : op_a / op_b;
            default: res = '0;
        endcase
    end

`ifdef APU_RESP_FLAGS_EN
    logic [FLAGS_W-1:0] flags;
    logic [FLAGS_W-1:0] rd_flags;

    always_comb begin
        flags = '0;
        case (apu_op_i)
            OP_ADD:  flags[FLAG_OVF] = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            OP_SUB:  flags[FLAG_OVF] = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
            OP_DIVU: flags[FLAG_DIV0] = (op_b == '0);
            OP_MUL, OP_MAC: flags = '0;
            default: flags[FLAG_ILLEGAL] = 1'b1;
        endcase
    end

    assign apu_flags_o = rd_flags;
`else
    assign apu_flags_o = '0;
`endif

    apu_nn_resp_slot_pipe #(
        .WIDTH   (WIDTH),
        .MAX_LAT (MAX_LAT),
        .IDX_W   (IDX_W)
    ) u_slot_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept),
        .wr_slot   (wr_slot),
        .wr_result (res),
`ifdef APU_RESP_FLAGS_EN
        .wr_flags  (flags),
        .rd_flags  (rd_flags),
`endif
        .occupancy (occupancy),
        .rd_valid  (apu_rvalid_o),
        .rd_result (apu_result_o)
    );

endmodule
